// File: rtl/keypad_emulator_if.sv
// Keypad-side signal bundle: key request handshake plus the column/row scan matrix.
// The master is the bench or sequencer; the slave is the emulated keypad.
interface keypad_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] col;
  logic [3:0] row;

  modport master (output key_valid, key_code, col, input key_ready, row);
  modport slave  (input key_valid, key_code, col, output key_ready, row);
endinterface

// File: rtl/keypad_emulator.sv
// Emulated 4x4 matrix keypad: presses one latched key with contact bounce and
// answers the scanner's active-low column drive on the row lines with zero latency.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a key request, key_ready high, contact open
// BOUNCE_IN  | press chatter, contact toggles starting closed
// HOLD       | contact firmly closed
// BOUNCE_OUT | release chatter, contact toggles starting open
// GAP        | contact open, settling before the next key is accepted
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 64,
  parameter int unsigned BOUNCE_CYCLES = 8,
  parameter int unsigned GAP_CYCLES    = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  keypad_emulator_if.slave   kp,
  output logic               contact,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HOLD,
    S_BOUNCE_OUT,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);
  localparam bit               HAS_BOUNCE = (BOUNCE_CYCLES > 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       code, code_nxt;
  logic             contact_nxt;
  logic             key_ready;
  logic             cnt_zero;

  assign cnt_zero     = (cnt == '0);
  assign kp.key_ready = key_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      code      <= 4'd0;
      contact   <= 1'b0;
      key_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      code      <= code_nxt;
      contact   <= contact_nxt;
      key_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    code_nxt    = code;
    contact_nxt = contact;

    case (state)
      S_IDLE: begin
        contact_nxt = 1'b0;
        if (kp.key_valid && key_ready) begin
          code_nxt    = kp.key_code;
          contact_nxt = 1'b1;
          if (HAS_BOUNCE) begin
            state_nxt = S_BOUNCE_IN;
            cnt_nxt   = BOUNCE_LD;
          end else begin
            state_nxt = S_HOLD;
            cnt_nxt   = HOLD_LD;
          end
        end
      end

      S_BOUNCE_IN: begin
        if (cnt_zero) begin
          state_nxt   = S_HOLD;
          cnt_nxt     = HOLD_LD;
          contact_nxt = 1'b1;
        end else begin
          cnt_nxt     = cnt - CNT_W'(1);
          contact_nxt = ~contact;
        end
      end

      S_HOLD: begin
        contact_nxt = 1'b1;
        if (cnt_zero) begin
          // Release chatter begins open, so both exits drop the contact.
          contact_nxt = 1'b0;
          if (HAS_BOUNCE) begin
            state_nxt = S_BOUNCE_OUT;
            cnt_nxt   = BOUNCE_LD;
          end else begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_LD;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      S_BOUNCE_OUT: begin
        if (cnt_zero) begin
          state_nxt   = S_GAP;
          cnt_nxt     = GAP_LD;
          contact_nxt = 1'b0;
        end else begin
          cnt_nxt     = cnt - CNT_W'(1);
          contact_nxt = ~contact;
        end
      end

      S_GAP: begin
        contact_nxt = 1'b0;
        if (cnt_zero) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_nxt   = S_IDLE;
        cnt_nxt     = '0;
        contact_nxt = 1'b0;
      end
    endcase
  end

  // Same-cycle row answer: the scanner samples row while it is still driving col.
  always_comb begin
    kp.row = 4'b1111;
    if (contact && !kp.col[code[1:0]]) begin
      kp.row[code[3:2]] = 1'b0;
    end
  end

endmodule
